reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter that shares one enabled D register (the FD1/FD2/FD4 family: clock, reset, EN, D, Q) between several requesters. It selects one pending requester, drives the register's EN and D for exactly one cycle, optionally reads back Q to confirm the write, then acknowledges the winner. The arbiter sits between the requesting logic and the shared register; the register instance itself stays outside this block.

## Interface
- N_REQ, 3: number of requesters, from 2 to 8.
- WIDTH, 4: width of the shared register's data in bits.

- clock  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester write request, level-sensitive.
- wdata  in  N_REQ*WIDTH  packed write data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant to the current winner; all zeros when idle.
- ack  out  N_REQ  one-cycle completion pulse to the winner.
- en  out  1  write enable to the shared register's EN.
- d  out  WIDTH  write data to the shared register's D.
- q  in  WIDTH  shared register's Q, used for readback.
- busy  out  1  high in every state except IDLE.
- err  out  1  readback mismatch pulse, coincident with ack.

## Operation
- FSM states: IDLE, GRANT, VERIFY, ACK.
- **IDLE**
  - If any req bit is set, pick the first set bit at or above pointer `ptr`, wrapping around modulo N_REQ.
  - Latch the winner index and its wdata slice, then go to GRANT.
  - If no req bit is set, stay in IDLE.
- **GRANT**
  - en=1, d=latched data, gnt[winner]=1.
  - Unconditionally go to VERIFY; with the readback feature compiled out, go to ACK.
- **VERIFY**
  - en=0, gnt is held.
  - Compare q to the latched data and register the result as mismatch.
  - Go to ACK.
- **ACK**
  - ack[winner]=1 for one cycle, gnt is held, err=mismatch.
  - Set ptr = (winner+1) mod N_REQ, then go to IDLE.
- Data is captured at grant time. A requester that drops req or changes wdata after IDLE does not affect the in-flight write, and the write still completes and is acknowledged.
- Requesters hold req until they see ack. A req still high in the IDLE cycle after ack is treated as a new request, arbitrated fairly against the others.
- Only one transaction is in flight at a time. req changes during busy are ignored until IDLE.
- All outputs are registered or decoded from registered state only; there is no combinational path from req or q to any output.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - gnt=0, ack=0, en=0, d=0, busy=0, err=0.
- Reset asserted in any state aborts the transaction on the next edge. No ack is issued for the aborted request, and en drops the same cycle state becomes IDLE.
- With readback (cycle 0 = IDLE with req sampled):
  - Cycle 1: GRANT, en high.
  - The shared register loads at the end of cycle 1.
  - Cycle 2: VERIFY, q valid.
  - Cycle 3: ACK.
  - Cycle 4: IDLE.
  - Request-to-ack latency is 3 cycles; throughput is 1 write per 4 cycles.
- Without readback: cycle 1 GRANT, cycle 2 ACK, cycle 3 IDLE. Latency is 2 cycles; throughput is 1 write per 3 cycles.
- en is high for exactly one cycle per transaction.
- Wrap-around: winner N_REQ-1 sets ptr=0.
- If all requesters assert simultaneously from reset, grants follow the order 0,1,…,N_REQ-1,0.

## Configuration
- Macro: ARB_READBACK_CHECK_EN.
- Defined: the VERIFY state exists and err reports q≠latched data at ack.
- Undefined: VERIFY is removed, GRANT goes directly to ACK, err is tied to 0, and q is unused.

## Structure
- A shared package/include `arb_pkg` holds:
  - the state encodings IDLE=2'd0, GRANT=2'd1, VERIFY=2'd2, ACK=2'd3;
  - the default values for N_REQ and WIDTH.
- One sub-module, `rr_pick`: a combinational rotating priority encoder.
  - Inputs: req, ptr.
  - Outputs: valid, index.
- The FSM, data latch and pointer stay in `reg_write_arbiter`.

## Test plan
- Single request: reset, then req=3'b010 with wdata slice 1 = 4'b0101. Expect gnt=3'b010 and en=1 for 1 cycle with d=4'b0101, then ack[1] 3 cycles after the request; readback gives q=4'b0101 and err=0.
- Fairness: req=3'b111 held continuously. Expect grants in the order 0,1,2,0, each 4 cycles apart (3 cycles apart without the macro).
- Wrap and skip: the pointer sits after a grant to requester 2, and req=3'b101. Expect requester 0 granted next, then requester 2.
- Mid-transaction drop: req[0] drops during GRANT. The write still lands, ack[0] still pulses, and d equals the data latched in IDLE.
- Readback error: force q to 4'b0000 while writing 4'b1010. Expect err=1 in the ack cycle; without the macro, err stays 0.
- Reset mid-op: assert reset during VERIFY. The next cycle shows all outputs 0 and state IDLE with no ack, and the following grant starts from requester 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin register write arbiter.
// FSM encodings and default sizing used by reg_write_arbiter and rr_pick.
package arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      VERIFY = 2'd2,
      ACK    = 2'd3
   } state_t;

   localparam int N_REQ_DEFAULT = 3;
   localparam int WIDTH_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set req bit at or above ptr,
// wrapping modulo N_REQ.
module rr_pick #(
   parameter  int N_REQ = arb_pkg::N_REQ_DEFAULT,
   localparam int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] ptr,
   output logic             valid,
   output logic [IDX_W-1:0] index
);

   localparam logic [IDX_W:0] NREQ_EXT = (IDX_W+1)'(N_REQ);

   logic [IDX_W:0] pos;

   // Walk offsets from farthest to nearest so the nearest set bit wins.
   always_comb begin
      valid = 1'b0;
      index = '0;
      pos   = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         pos = {1'b0, ptr} + (IDX_W+1)'(k);
         if (pos >= NREQ_EXT) begin
            pos = pos - NREQ_EXT;
         end
         if (req[pos[IDX_W-1:0]]) begin
            valid = 1'b1;
            index = pos[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one enabled D register between N_REQ requesters.
// Define ARB_READBACK_CHECK_EN to add the VERIFY state and the q readback check.
module reg_write_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ = N_REQ_DEFAULT,
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] wdata,
   output logic [N_REQ-1:0]       gnt,
   output logic [N_REQ-1:0]       ack,
   output logic                   en,
   output logic [WIDTH-1:0]       d,
   input  logic [WIDTH-1:0]       q,
   output logic                   busy,
   output logic                   err
);

   localparam int IDX_W = $clog2(N_REQ);

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] pick_index;
   logic             pick_valid;
   logic [WIDTH-1:0] data_lat;
   logic             mismatch;

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(N_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .valid (pick_valid),
      .index (pick_index)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= next_state;
         if (state == ACK) begin
            ptr <= next_ptr(winner);
         end
      end
   end

   // Winner and data are only observed outside IDLE, so they need no reset.
   always_ff @(posedge clock) begin
      if (state == IDLE && pick_valid) begin
         winner   <= pick_index;
         data_lat <= wdata[pick_index*WIDTH +: WIDTH];
      end
   end

`ifdef ARB_READBACK_CHECK_EN
   always_ff @(posedge clock) begin
      if (state == VERIFY) begin
         mismatch <= (q != data_lat);
      end
   end
`else
   logic unused_q;
   assign unused_q = ^q;
   assign mismatch = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (pick_valid) begin
               next_state = GRANT;
            end
         end
         GRANT: begin
`ifdef ARB_READBACK_CHECK_EN
            next_state = VERIFY;
`else
            next_state = ACK;
`endif
         end
`ifdef ARB_READBACK_CHECK_EN
         VERIFY: next_state = ACK;
`endif
         ACK:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Outputs decode registered state only; req and q never reach them directly.
   always_comb begin
      gnt  = '0;
      ack  = '0;
      en   = (state == GRANT);
      d    = '0;
      busy = (state != IDLE);
      err  = (state == ACK) && mismatch;
      if (state != IDLE) begin
         gnt = onehot(winner);
      end
      if (state == ACK) begin
         ack = onehot(winner);
      end
      if (en) begin
         d = data_lat;
      end
   end

   a_gnt_onehot : assert property (@(posedge clock) disable iff (reset) $onehot0(gnt));
   a_en_single  : assert property (@(posedge clock) disable iff (reset) en |=> !en);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter; honours ARB_READBACK_CHECK_EN.
// Models the shared register locally and checks grant order, data, ack and err.
module tb_reg_write_arbiter;

   localparam int N = 3;
   localparam int W = 4;
`ifdef ARB_READBACK_CHECK_EN
   localparam int   LAT     = 3;
   localparam logic EXP_ERR = 1'b1;
`else
   localparam int   LAT     = 2;
   localparam logic EXP_ERR = 1'b0;
`endif
   localparam int PERIOD = LAT + 1;

   typedef struct {
      logic [N-1:0] gnt;
      logic [W-1:0] data;
      logic         err;
   } exp_t;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] wdata = '0;
   logic [N-1:0]   gnt;
   logic [N-1:0]   ack;
   logic           en;
   logic [W-1:0]   d;
   logic [W-1:0]   q;
   logic [W-1:0]   reg_q;
   logic           busy;
   logic           err;
   logic           force_zero = 1'b0;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clock = ~clock;

   reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .req   (req),
      .wdata (wdata),
      .gnt   (gnt),
      .ack   (ack),
      .en    (en),
      .d     (d),
      .q     (q),
      .busy  (busy),
      .err   (err)
   );

   // Shared enabled D register living outside the arbiter.
   always_ff @(posedge clock) begin
      if (reset) reg_q <= '0;
      else if (en) reg_q <= d;
   end
   assign q = force_zero ? '0 : reg_q;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_en(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!en && cyc < 20);
      if (!en) check_eq("en_timeout", 32'(cyc), 32'(0));
   endtask

   task automatic wait_ack(output int cyc);
      cyc = 0;
      while (ack == '0 && cyc < 20) begin
         tick();
         cyc++;
      end
      if (ack == '0) check_eq("ack_timeout", 32'(cyc), 32'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_gnt"},  32'(gnt),  32'(0));
      check_eq({tag, "_ack"},  32'(ack),  32'(0));
      check_eq({tag, "_en"},   32'(en),   32'(0));
      check_eq({tag, "_d"},    32'(d),    32'(0));
      check_eq({tag, "_busy"}, 32'(busy), 32'(0));
      check_eq({tag, "_err"},  32'(err),  32'(0));
   endtask

   task automatic push_exp(input logic [N-1:0] g, input logic [W-1:0] dat, input logic e);
      exp_t x;
      x.gnt  = g;
      x.data = dat;
      x.err  = e;
      exp_q.push_back(x);
   endtask

   // Scoreboard: en cycles are checked against the head, ack cycles pop it.
   always @(negedge clock) begin
      if (!reset) begin
         if (en) begin
            if (exp_q.size() == 0) begin
               check_eq("en_unexpected", 32'(en), 32'(0));
            end else begin
               check_eq("gnt_at_en", 32'(gnt), 32'(exp_q[0].gnt));
               check_eq("d_at_en", 32'(d), 32'(exp_q[0].data));
            end
         end
         if (ack != '0) begin
            if (exp_q.size() == 0) begin
               check_eq("ack_unexpected", 32'(ack), 32'(0));
            end else begin
               mon_e = exp_q.pop_front();
               check_eq("ack_winner", 32'(ack), 32'(mon_e.gnt));
               check_eq("err_at_ack", 32'(err), 32'(mon_e.err));
            end
         end else begin
            check_eq("err_outside_ack", 32'(err), 32'(0));
         end
      end
   end

   initial begin
      int c;
      int total;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;

      // Single request with readback
      req   = 3'b010;
      wdata = 12'h050;
      push_exp(3'b010, 4'h5, 1'b0);
      wait_en(c);
      check_eq("single_en_latency", 32'(c), 32'(1));
      check_eq("single_busy", 32'(busy), 32'(1));
      tick();
      check_eq("single_en_one_cycle", 32'(en), 32'(0));
      total = 2;
      wait_ack(c);
      total += c;
      check_eq("single_ack_latency", 32'(total), 32'(LAT));
      check_eq("single_q", 32'(q), 32'(4'h5));
      req = '0;
      tick();
      check_eq("single_idle", 32'(busy), 32'(0));

      // Fairness from reset with all requesters held
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      req   = 3'b111;
      wdata = 12'hCBA;
      push_exp(3'b001, 4'hA, 1'b0);
      push_exp(3'b010, 4'hB, 1'b0);
      push_exp(3'b100, 4'hC, 1'b0);
      push_exp(3'b001, 4'hA, 1'b0);
      for (int g = 0; g < 4; g++) begin
         wait_en(c);
         check_eq("fair_gnt", 32'(gnt), 32'(1 << (g % N)));
         if (g == 0) check_eq("fair_first_latency", 32'(c), 32'(1));
         else        check_eq("fair_spacing", 32'(c), 32'(PERIOD));
      end
      wait_ack(c);
      req = '0;
      tick();
      check_eq("fair_idle", 32'(busy), 32'(0));

      // Park the pointer after requester 2, then wrap and skip
      req   = 3'b100;
      wdata = 12'h700;
      push_exp(3'b100, 4'h7, 1'b0);
      wait_en(c);
      wait_ack(c);
      req = '0;
      tick();
      req   = 3'b101;
      wdata = 12'h609;
      push_exp(3'b001, 4'h9, 1'b0);
      push_exp(3'b100, 4'h6, 1'b0);
      wait_en(c);
      check_eq("wrap_first", 32'(gnt), 32'(3'b001));
      wait_ack(c);
      req = 3'b100;
      wait_en(c);
      check_eq("skip_second", 32'(gnt), 32'(3'b100));
      wait_ack(c);
      req = '0;
      tick();
      check_eq("wrap_idle", 32'(busy), 32'(0));

      // Requester drops req and changes data while its write is in flight
      req   = 3'b001;
      wdata = 12'h00E;
      push_exp(3'b001, 4'hE, 1'b0);
      wait_en(c);
      req   = '0;
      wdata = 12'h003;
      wait_ack(c);
      check_eq("drop_ack", 32'(ack), 32'(3'b001));
      check_eq("drop_q_landed", 32'(q), 32'(4'hE));
      tick();
      check_eq("drop_idle", 32'(busy), 32'(0));

      // Readback mismatch
      req        = 3'b010;
      wdata      = 12'h0A0;
      force_zero = 1'b1;
      push_exp(3'b010, 4'hA, EXP_ERR);
      wait_en(c);
      wait_ack(c);
      check_eq("readback_err", 32'(err), 32'(EXP_ERR));
      req = '0;
      tick();
      force_zero = 1'b0;
      check_eq("readback_idle", 32'(busy), 32'(0));

      // Reset mid-transaction aborts without ack and restarts the pointer
      req   = 3'b010;
      wdata = 12'h050;
      push_exp(3'b010, 4'h5, 1'b0);
      wait_en(c);
`ifdef ARB_READBACK_CHECK_EN
      tick();
`endif
      reset = 1'b1;
      tick();
      check_all_zero("abort");
      exp_q.delete();
      reset = 1'b0;
      req   = 3'b111;
      wdata = 12'h321;
      push_exp(3'b001, 4'h1, 1'b0);
      wait_en(c);
      check_eq("post_reset_gnt", 32'(gnt), 32'(3'b001));
      wait_ack(c);
      req = '0;
      tick();
      check_eq("post_reset_idle", 32'(busy), 32'(0));

      tick();
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
